// File: rtl/input_quantizer_packer.sv
// Quantizes raw feature samples to 2-bit codes against three thresholds and packs
// NUM_FEAT codes into one output vector with a valid/ready handoff and a vector counter.
module input_quantizer_packer #(
  parameter int unsigned NUM_FEAT = 3,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       thr0,
  input  logic [IN_W-1:0]       thr1,
  input  logic [IN_W-1:0]       thr2,
  input  logic                  sync,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [2*NUM_FEAT-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      vec_count
);

  localparam int unsigned IdxW    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned DataW   = 2 * NUM_FEAT;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FEAT - 1);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       code;
  logic             accept;
  logic             handshake;
  logic             complete;
  logic [IdxW-1:0]  base_idx;
  logic [DataW-1:0] base_acc;
  logic [DataW-1:0] ins;

  // Only the last slot can stall: it needs the output register to be free.
  assign in_ready  = (idx_q != LastIdx) || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    code = 2'd0;
    if (in_data >= thr2) begin
      code = 2'd3;
    end else if (in_data >= thr1) begin
      code = 2'd2;
    end else if (in_data >= thr0) begin
      code = 2'd1;
    end
  end

  always_comb begin
    // A sync in the same cycle as an accept restarts the frame first, so the
    // sample lands in slot 0.
    base_idx    = sync ? '0 : idx_q;
    base_acc    = sync ? '0 : acc_q;
    complete    = accept && (base_idx == LastIdx);
    idx_d       = base_idx;
    acc_d       = base_acc;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    ins         = base_acc;

    if (handshake) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + 1'b1;
    end

    if (accept) begin
      for (int unsigned i = 0; i < NUM_FEAT; i++) begin
        if (base_idx == IdxW'(i)) begin
          ins[2*i +: 2] = code;
        end
      end
      if (complete) begin
        out_data_d  = ins;
        out_valid_d = 1'b1;
        idx_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = ins;
        idx_d = base_idx + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_input_quantizer_packer.sv
// Scoreboard bench for input_quantizer_packer: stimulus pushes expected vectors, a
// monitor pops and compares on every output handshake.
module tb_input_quantizer_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] thr0, thr1, thr2, in_data;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_data;
  logic [3:0] vec_count;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];
  logic [3:0] model_cnt;

  logic [7:0] samp [3][3];
  logic [5:0] vexp [3];

  always #5 clk = ~clk;

  input_quantizer_packer #(
    .NUM_FEAT(3),
    .IN_W    (8),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .thr0     (thr0),
    .thr1     (thr1),
    .thr2     (thr2),
    .sync     (sync),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .vec_count(vec_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Present one sample and return on the falling edge after it was accepted.
  task automatic send(input logic [7:0] x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0 for sample %0d", x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [5:0] e);
    exp_q.push_back(e);
    send(a);
    send(b);
    send(c);
  endtask

  // Monitor: compare each handed-off vector and the count seen before the handshake.
  initial begin
    model_cnt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        model_cnt = '0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got 0x%0h, expected no vector", out_data);
        end else begin
          chk("vector", {10'd0, out_data}, {10'd0, exp_q.pop_front()});
        end
        chk("count_at_handshake", {12'd0, vec_count}, {12'd0, model_cnt});
        model_cnt = model_cnt + 4'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    samp[0][0] = 8'd10;  samp[0][1] = 8'd130; samp[0][2] = 8'd200; vexp[0] = 6'b111000;
    samp[1][0] = 8'd63;  samp[1][1] = 8'd64;  samp[1][2] = 8'd191; vexp[1] = 6'b100100;
    samp[2][0] = 8'd128; samp[2][1] = 8'd192; samp[2][2] = 8'd255; vexp[2] = 6'b111110;

    thr0 = 8'd64;
    thr1 = 8'd128;
    thr2 = 8'd192;
    rst = 1'b1;
    sync = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", {10'd0, out_data}, 16'd0);
    chk("rst_vec_count", {12'd0, vec_count}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic vector, zero-latency valid
    vec(8'd10, 8'd130, 8'd200, 6'b111000);
    #1;
    chk("basic_valid", {15'd0, out_valid}, 16'd1);
    chk("basic_data", {10'd0, out_data}, 16'h38);
    @(negedge clk);
    #1;
    chk("basic_count", {12'd0, vec_count}, 16'd1);

    // Threshold boundaries, back to back
    vec(8'd63, 8'd64, 8'd191, 6'b100100);
    vec(8'd128, 8'd192, 8'd255, 6'b111110);
    @(negedge clk);
    #1;
    chk("bound_count", {12'd0, vec_count}, 16'd3);
    chk("bound_idle", {15'd0, out_valid}, 16'd0);

    // Backpressure: hold first vector, stall on last slot, release without bubble
    @(negedge clk);
    out_ready = 1'b0;
    vec(8'd10, 8'd130, 8'd200, 6'b111000);
    exp_q.push_back(6'b100100);
    send(8'd63);
    send(8'd64);
    in_valid = 1'b1;
    in_data  = 8'd191;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_data", {10'd0, out_data}, 16'h38);
      chk("hold_count", {12'd0, vec_count}, 16'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_valid", {15'd0, out_valid}, 16'd1);
    chk("b2b_data", {10'd0, out_data}, 16'h24);
    chk("b2b_count", {12'd0, vec_count}, 16'd4);
    @(negedge clk);
    #1;
    chk("drain_valid", {15'd0, out_valid}, 16'd0);
    chk("drain_count", {12'd0, vec_count}, 16'd5);

    // Sync discards partial vector
    send(8'd255);
    send(8'd10);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    vec(8'd255, 8'd0, 8'd0, 6'b000011);
    #1;
    chk("sync_data", {10'd0, out_data}, 16'h03);
    // Sync coinciding with an accepted sample puts it in slot 0
    send(8'd200);
    sync = 1'b1;
    exp_q.push_back(6'b111001);
    send(8'd64);
    sync = 1'b0;
    send(8'd128);
    send(8'd192);
    @(negedge clk);
    #1;
    chk("sync_count", {12'd0, vec_count}, 16'd7);

    // Reset mid-vector with a held output
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd10);
    send(8'd130);
    send(8'd200);
    send(8'd255);
    send(8'd255);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_out_data", {10'd0, out_data}, 16'd0);
    chk("midrst_vec_count", {12'd0, vec_count}, 16'd0);
    chk("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    vec(8'd63, 8'd64, 8'd191, 6'b100100);
    @(negedge clk);
    #1;
    chk("fresh_count", {12'd0, vec_count}, 16'd1);

    // 4-bit counter wrap over 17 handshakes
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      vec(samp[k % 3][0], samp[k % 3][1], samp[k % 3][2], vexp[k % 3]);
      @(negedge clk);
      #1;
      chk("wrap_count", 16'(vec_count), 16'(k % 16));
    end

    @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
